vga_sync_decoder: RTL



---
 rtl/vga_sync_decoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds pixel coordinates, active-video strobe and lock status from an h/v sync pair.
// Define VGA_SYNC_DEC_STATS_EN to add the err_count and line_len status outputs.
module vga_sync_decoder #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       h_sync,
  input  logic       v_sync,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err
`ifdef VGA_SYNC_DEC_STATS_EN
  ,
  output logic [7:0] err_count,
  output logic [9:0] line_len
`endif
);
  localparam logic [10:0] H_TOTAL = 11'(H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH);
  localparam logic [10:0] V_TOTAL = 11'(V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH);
  localparam logic [9:0] HS_W = 10'(H_SYNC);
  localparam logic [9:0] VS_W = 10'(V_SYNC);
  localparam logic [9:0] H_BEG = 10'(H_BACK_PORCH);
  localparam logic [9:0] H_END = 10'(H_BACK_PORCH + H_ACTIVE);
  localparam logic [9:0] V_BEG = 10'(V_BACK_PORCH);
  localparam logic [9:0] V_END = 10'(V_BACK_PORCH + V_ACTIVE);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [9:0] SAT = 10'h3ff;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t     state_q, state_d;
  logic       hs_q, hs_p_q, vs_q, vs_p_q;
  logic [9:0] h_cnt_q, h_cnt_d, hs_low_q, hs_low_d, v_cnt_q, v_cnt_d, vs_lines_q, vs_lines_d;
  logic       v_pend_q, v_pend_d, h_seen_q, h_seen_d;
  logic [3:0] good_q, good_d;
  logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic       pix_valid_q, pix_valid_d, frame_start_q, frame_start_d, timing_err_q, timing_err_d;
  logic       h_rise, v_rise, v_clr, line_err, frame_err, lost_err, err, active;

  always_comb begin
    h_rise     = hs_q & ~hs_p_q;
    v_rise     = vs_q & ~vs_p_q;
    v_clr      = h_rise & (v_rise | v_pend_q);
    v_pend_d   = (v_rise | v_pend_q) & ~h_rise;
    h_cnt_d    = h_rise ? '0 : h_cnt_q + {9'd0, h_cnt_q != SAT};
    hs_low_d   = h_rise ? '0 : hs_low_q + {9'd0, ~hs_q & (hs_low_q != SAT)};
    v_cnt_d    = v_clr ? '0 : v_cnt_q + {9'd0, h_rise & (v_cnt_q != SAT)};
    vs_lines_d = v_clr ? '0 : vs_lines_q + {9'd0, h_rise & ~vs_q & (vs_lines_q != SAT)};
    h_seen_d   = h_seen_q | h_rise;
    // the first rise after reset closes a partial line, so it is not measured
    line_err   = h_rise & h_seen_q & ((hs_low_q != HS_W) || ({1'b0, h_cnt_q} + 11'd1 != H_TOTAL));
    frame_err  = v_clr & ((vs_lines_q != VS_W) || ({1'b0, v_cnt_q} + 11'd1 != V_TOTAL));
    lost_err   = h_cnt_q == SAT;
    err        = (state_q != SEARCH) & (line_err | frame_err | lost_err);
    state_d    = state_q;
    good_d     = good_q;
    if (err) begin
      state_d = SEARCH;
      good_d  = '0;
    end else if (v_clr && state_q != LOCKED) begin
      // the frame boundary that ends the search counts as the first good frame
      good_d  = good_q + 4'd1;
      state_d = (good_d >= LOCK_N) ? LOCKED : ACQUIRE;
    end
    active        = (v_cnt_q >= V_BEG) && (v_cnt_q < V_END) && (h_cnt_q >= H_BEG) && (h_cnt_q < H_END);
    pix_valid_d   = active & (state_q == LOCKED);
    pix_x_d       = pix_valid_d ? h_cnt_q - H_BEG : pix_x_q;
    pix_y_d       = pix_valid_d ? v_cnt_q - V_BEG : pix_y_q;
    frame_start_d = pix_valid_d & (h_cnt_q == H_BEG) & (v_cnt_q == V_BEG);
    timing_err_d  = err;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      hs_p_q        <= 1'b1;
      vs_q          <= 1'b1;
      vs_p_q        <= 1'b1;
      h_cnt_q       <= '0;
      hs_low_q      <= '0;
      v_cnt_q       <= '0;
      vs_lines_q    <= '0;
      v_pend_q      <= 1'b0;
      h_seen_q      <= 1'b0;
      good_q        <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= h_sync;
      hs_p_q        <= hs_q;
      vs_q          <= v_sync;
      vs_p_q        <= vs_q;
      h_cnt_q       <= h_cnt_d;
      hs_low_q      <= hs_low_d;
      v_cnt_q       <= v_cnt_d;
      vs_lines_q    <= vs_lines_d;
      v_pend_q      <= v_pend_d;
      h_seen_q      <= h_seen_d;
      good_q        <= good_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      timing_err_q  <= timing_err_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = state_q == LOCKED;
  assign timing_err  = timing_err_q;

`ifdef VGA_SYNC_DEC_STATS_EN
  logic [7:0] err_count_q, err_count_d;
  logic [9:0] line_len_q, line_len_d;

  always_comb begin
    err_count_d = err_count_q + {7'd0, timing_err_q & (err_count_q != 8'hff)};
    line_len_d  = h_rise ? h_cnt_q + 10'd1 : line_len_q;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err_count_q <= '0;
      line_len_q  <= '0;
    end else begin
      err_count_q <= err_count_d;
      line_len_q  <= line_len_d;
    end
  end

  assign err_count = err_count_q;
  assign line_len  = line_len_q;
`endif
endmodule
